// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   - Default address/data widths
//   - ERR_RDATA: read data returned when a memory access times out
//   - arb_state_t: arbiter FSM states (IDLE/BUSY/RESP)
//   - grant_t: which core port owns the memory (GNT_INSTR/GNT_DATA)
package riscv_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        GNT_INSTR,
        GNT_DATA
    } grant_t;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Unified-memory arbiter between the core's instruction-fetch port and its
// load/store port. One access is in flight at a time. Simultaneous requests
// are served round-robin. Misaligned word addresses are rejected without
// touching memory. An access that waits too long for mem_ack is abandoned
// with an error.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   i_req, i_addr                  fetch request, held until i_ack
//   i_ack, i_rdata, i_err          fetch completion pulse, word and error
//   d_req, d_we, d_addr, d_wdata   load/store request, held until d_ack
//   d_ack, d_rdata, d_err          load/store completion pulse, data and error
//   mem_req, mem_we, mem_addr,
//   mem_wdata                      memory strobe (held until mem_ack) and payload
//   mem_ack, mem_rdata             memory completion and read data
//   stall                          a request is pending and not yet acked
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              stall
);

    // A zero TIMEOUT disables the timeout; keep the counter at least one bit
    // wide so the declarations stay legal in that case.
    localparam int CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TMO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TMO_LAST = TMO_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_t        state;
    arb_state_t        next_state;
    grant_t            grant;
    grant_t            last_grant;
    grant_t            sel;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_misaligned;
    logic              any_req;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              tmo_hit;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    assign any_req = i_req | d_req;

    // The counter holds the number of BUSY cycles already spent without
    // mem_ack, so the cycle in which it equals TIMEOUT-1 is the last cycle
    // mem_req is allowed to stay high.
    assign tmo_hit = (TIMEOUT > 0) && (tmo_cnt == TMO_LAST);

    // Grant selection and next-state decode. On a conflict, the port that
    // was not served last wins.
    always_comb begin
        next_state     = state;
        sel            = GNT_INSTR;
        sel_addr       = i_addr;
        sel_misaligned = 1'b0;

        if (i_req && d_req) begin
            sel = (last_grant == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
        end else if (d_req) begin
            sel = GNT_DATA;
        end

        sel_addr       = (sel == GNT_DATA) ? d_addr : i_addr;
        sel_misaligned = (sel_addr[1:0] != 2'b00);

        case (state)
            IDLE: begin
                if (any_req) begin
                    next_state = sel_misaligned ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (mem_ack || tmo_hit) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant bookkeeping, latched memory payload, timeout counter and the
    // registered response. The payload is captured once at grant so a
    // requester changing its inputs during BUSY cannot disturb the access.
    // A mem_ack in the timeout cycle wins over the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant      <= GNT_INSTR;
            last_grant <= GNT_INSTR;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            tmo_cnt    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= sel;
                        mem_addr   <= sel_addr;
                        mem_we     <= (sel == GNT_DATA) && d_we;
                        mem_wdata  <= (sel == GNT_DATA) ? d_wdata : '0;
                        tmo_cnt    <= '0;
                        resp_rdata <= '0;
                        resp_err   <= sel_misaligned;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        resp_rdata <= mem_we ? '0 : mem_rdata;
                        resp_err   <= 1'b0;
                    end else if (tmo_hit) begin
                        resp_rdata <= DATA_W'(ERR_RDATA);
                        resp_err   <= 1'b1;
                    end else if (tmo_cnt != CNT_MAX) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    last_grant <= grant;
                end
                default: begin
                end
            endcase
        end
    end

    // Memory strobe and acks decode directly from the state register, so
    // they drop to zero the moment reset is applied.
    assign mem_req = (state == BUSY);
    assign i_ack   = (state == RESP) && (grant == GNT_INSTR);
    assign d_ack   = (state == RESP) && (grant == GNT_DATA);
    assign i_err   = i_ack & resp_err;
    assign d_err   = d_ack & resp_err;
    assign i_rdata = resp_rdata;
    assign d_rdata = resp_rdata;

    assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter. A behavioural memory answers
// mem_req after a programmable latency. A transaction-level reference model
// predicts grant order, ack cycles, memory-strobe windows and response data
// for each request pair. All stimulus starts one time unit after a rising
// edge, and outputs are sampled one unit later.
module tb_riscv_mem_arbiter;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Memory environment state and reference-model state.
    logic [31:0] phys_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];
    int  mem_latency   = 0;
    bit  mem_never     = 1'b0;
    int  inject_at     = -1;
    int  mem_wait      = 0;
    bit  ref_last_data = 1'b0;

    riscv_mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Memory responder: acks in the (mem_latency+1)-th cycle of mem_req,
    // holds ack for one cycle, and can inject a stray ack at a chosen cycle.
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            mem_wait  = 0;
        end else if (cyc == inject_at) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
        end else if (mem_req && !mem_never) begin
            if (mem_wait >= mem_latency) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    phys_mem[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata = phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : init_word(mem_addr);
                end
                mem_wait = 0;
            end else begin
                mem_wait++;
            end
        end else begin
            mem_wait = 0;
        end
    end

    // Issues a fetch and/or data request in cycle 0 and checks every cycle
    // against the transaction-level prediction. Entry and exit are one time
    // unit after a rising edge with the arbiter idle.
    task automatic run_pair(input bit do_i, input logic [31:0] ia,
                            input bit do_d, input bit dwe,
                            input logic [31:0] da, input logic [31:0] dwd,
                            input int lat, input bit never, input int inject_off,
                            input bit scramble, input string tag);
        bit          act [2];
        bit          mis [2];
        bit          tmo [2];
        bit          we_p [2];
        logic [31:0] addr_p [2];
        logic [31:0] wd_p [2];
        int          g [2];
        int          a [2];
        logic [31:0] erd [2];
        bit          eer [2];
        int          first;
        int          second;
        int          last_c;
        bit          exp_ia;
        bit          exp_da;
        bit          exp_mr;
        bit          exp_st;
        int          srv;

        act[0] = do_i;  act[1] = do_d;
        addr_p[0] = ia; addr_p[1] = da;
        we_p[0] = 1'b0; we_p[1] = dwe;
        wd_p[0] = '0;   wd_p[1] = dwd;

        if (do_i && do_d) first = ref_last_data ? 0 : 1;
        else              first = do_d ? 1 : 0;
        second = 1 - first;

        for (int p = 0; p < 2; p++) begin
            mis[p] = (addr_p[p] % 4) != 0;
            tmo[p] = !mis[p] && (never || lat >= TMO);
        end

        g[first] = 0;
        a[first] = mis[first] ? 1 : (tmo[first] ? TMO + 1 : lat + 2);
        g[second] = 0;
        a[second] = 0;
        if (act[second]) begin
            g[second] = a[first] + 1;
            a[second] = g[second] + (mis[second] ? 1 : (tmo[second] ? TMO + 1 : lat + 2));
        end
        last_c = act[second] ? a[second] : a[first];

        for (int k = 0; k < 2; k++) begin
            int p;
            p = (k == 0) ? first : second;
            erd[p] = '0;
            eer[p] = 1'b0;
            if (act[p]) begin
                if (mis[p]) begin
                    erd[p] = 32'h0;
                    eer[p] = 1'b1;
                end else if (tmo[p]) begin
                    erd[p] = 32'hDEADBEEF;
                    eer[p] = 1'b1;
                end else if (we_p[p]) begin
                    ref_mem[addr_p[p]] = wd_p[p];
                    erd[p] = 32'h0;
                end else begin
                    erd[p] = ref_read(addr_p[p]);
                end
                ref_last_data = (p == 1);
            end
        end

        for (int c = 0; c <= last_c + 6; c++) begin
            if (c == 0) begin
                i_req       = do_i;
                i_addr      = ia;
                d_req       = do_d;
                d_we        = dwe;
                d_addr      = da;
                d_wdata     = dwd;
                mem_latency = lat;
                mem_never   = never;
                if (inject_off >= 0) inject_at = cyc + inject_off;
            end
            if (act[0] && c == a[0] + 1) i_req = 1'b0;
            if (act[1] && c == a[1] + 1) d_req = 1'b0;
            if (scramble && c >= 1 && c < a[first]) begin
                if (first == 0) begin
                    i_addr = $urandom;
                end else begin
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                end
            end
            #1;

            exp_ia = act[0] && (c == a[0]);
            exp_da = act[1] && (c == a[1]);
            exp_st = (act[0] && c < a[0]) || (act[1] && c < a[1]);
            exp_mr = 1'b0;
            srv    = -1;
            for (int p = 0; p < 2; p++) begin
                if (act[p] && !mis[p] && c >= g[p] + 1 && c <= a[p] - 1) begin
                    exp_mr = 1'b1;
                    srv    = p;
                end
            end

            checks++;
            if (i_ack !== exp_ia) begin
                failures++;
                $display("[TB] FAIL %s i_ack c=%0d got=%b exp=%b", tag, c, i_ack, exp_ia);
            end
            checks++;
            if (d_ack !== exp_da) begin
                failures++;
                $display("[TB] FAIL %s d_ack c=%0d got=%b exp=%b", tag, c, d_ack, exp_da);
            end
            checks++;
            if (mem_req !== exp_mr) begin
                failures++;
                $display("[TB] FAIL %s mem_req c=%0d got=%b exp=%b", tag, c, mem_req, exp_mr);
            end
            checks++;
            if (stall !== exp_st) begin
                failures++;
                $display("[TB] FAIL %s stall c=%0d got=%b exp=%b", tag, c, stall, exp_st);
            end
            if (srv >= 0) begin
                checks++;
                if (mem_addr !== addr_p[srv] || mem_we !== we_p[srv]) begin
                    failures++;
                    $display("[TB] FAIL %s mem_addr/we c=%0d got=%h/%b exp=%h/%b",
                             tag, c, mem_addr, mem_we, addr_p[srv], we_p[srv]);
                end
                if (we_p[srv]) begin
                    checks++;
                    if (mem_wdata !== wd_p[srv]) begin
                        failures++;
                        $display("[TB] FAIL %s mem_wdata c=%0d got=%h exp=%h", tag, c, mem_wdata, wd_p[srv]);
                    end
                end
            end
            if (exp_ia) begin
                checks++;
                if (i_rdata !== erd[0] || i_err !== eer[0]) begin
                    failures++;
                    $display("[TB] FAIL %s i_resp c=%0d got=%h/%b exp=%h/%b", tag, c, i_rdata, i_err, erd[0], eer[0]);
                end
            end
            if (exp_da) begin
                checks++;
                if (d_rdata !== erd[1] || d_err !== eer[1]) begin
                    failures++;
                    $display("[TB] FAIL %s d_resp c=%0d got=%h/%b exp=%h/%b", tag, c, d_rdata, d_err, erd[1], eer[1]);
                end
            end

            @(posedge clk);
            #1;
        end
        mem_never = 1'b0;
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_mem got req=%b we=%b addr=%h wdata=%h exp all 0", mem_req, mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (i_ack !== 1'b0 || d_ack !== 1'b0 || i_err !== 1'b0 || d_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ack got i_ack=%b d_ack=%b i_err=%b d_err=%b exp all 0", i_ack, d_ack, i_err, d_err);
        end
        checks++;
        if (i_rdata !== 32'h0 || d_rdata !== 32'h0 || stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_data got i_rdata=%h d_rdata=%h stall=%b exp 0", i_rdata, d_rdata, stall);
        end
        @(posedge clk);
        #1;
        rst           = 1'b0;
        ref_last_data = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fetch_only;
        phys_mem[32'h10] = 32'h00500093;
        ref_mem[32'h10]  = 32'h00500093;
        run_pair(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, -1, 1'b0, "fetch_only");
    endtask

    task automatic test_simultaneous;
        phys_mem[32'h100] = 32'hCAFE0001;
        ref_mem[32'h100]  = 32'hCAFE0001;
        run_pair(1'b1, 32'h4, 1'b1, 1'b0, 32'h100, 32'h0, 2, 1'b0, -1, 1'b0, "simul_data_first");
        run_pair(1'b0, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0, 0, 1'b0, -1, 1'b0, "simul_data_alone");
        run_pair(1'b1, 32'h8, 1'b1, 1'b0, 32'h100, 32'h0, 0, 1'b0, -1, 1'b0, "simul_fetch_first");
    endtask

    task automatic test_store;
        run_pair(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h12345678, 1, 1'b0, -1, 1'b0, "store");
        run_pair(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 0, 1'b0, -1, 1'b0, "store_readback");
    endtask

    task automatic test_misaligned;
        run_pair(1'b0, 32'h0, 1'b1, 1'b0, 32'h102, 32'h0, 0, 1'b0, -1, 1'b0, "misaligned_load");
        run_pair(1'b1, 32'h6, 1'b1, 1'b1, 32'h300, 32'hA5A5A5A5, 0, 1'b0, -1, 1'b0, "misaligned_fetch_pair");
    endtask

    task automatic test_timeout;
        run_pair(1'b0, 32'h0, 1'b1, 1'b0, 32'h180, 32'h0, 0, 1'b1, 20, 1'b0, "timeout_late_ack");
        run_pair(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, TMO - 1, 1'b0, -1, 1'b0, "timeout_coincident_ack");
        run_pair(1'b1, 32'h24, 1'b0, 1'b0, 32'h0, 32'h0, TMO, 1'b0, -1, 1'b0, "timeout_one_late");
    endtask

    task automatic test_reset_busy;
        i_req       = 1'b1;
        i_addr      = 32'h40;
        mem_latency = 5;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
        end
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_busy_pre mem_req got=%b exp=1", mem_req);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy_now got mem_req=%b i_ack=%b d_ack=%b exp 0", mem_req, i_ack, d_ack);
        end
        i_req = 1'b0;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        ref_last_data = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if (i_ack !== 1'b0 || d_ack !== 1'b0 || mem_req !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_busy_after c=%0d got i_ack=%b d_ack=%b mem_req=%b exp 0", c, i_ack, d_ack, mem_req);
            end
            @(posedge clk);
            #1;
        end
        run_pair(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1, 1'b0, -1, 1'b0, "reset_busy_recover");
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [31:0] ia;
            logic [31:0] da;
            int          lat;
            kind = $urandom_range(0, 2);
            ia   = 32'h1000 + 4 * $urandom_range(0, 15);
            da   = 32'h1000 + 4 * $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) ia = ia + $urandom_range(1, 3);
            if ($urandom_range(0, 7) == 0) da = da + $urandom_range(1, 3);
            lat = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 1, TMO + 1) : $urandom_range(0, 3);
            run_pair(kind != 1, ia, kind != 0, 1'($urandom_range(0, 1)), da, $urandom,
                     lat, 1'b0, -1, 1'($urandom_range(0, 1)), $sformatf("random%0d", n));
        end
    endtask

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        test_reset;
        test_fetch_only;
        test_simultaneous;
        test_store;
        test_misaligned;
        test_timeout;
        test_reset_busy;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

endmodule
